// File: rtl/rv_mem_pkg.sv
// Shared memory-access codes, store-buffer entry layout and byte-lane mask helper.
// Used by both the store write buffer and the load-extension logic.
package rv_mem_pkg;

  localparam int WADDR_W = 30;

  typedef enum logic [2:0] {
    ST_SB   = 3'b000,
    ST_SH   = 3'b001,
    ST_SW   = 3'b010,
    ST_NONE = 3'b111
  } st_type_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } ld_type_e;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [3:0]         mask;
    logic [31:0]        data;
  } sb_entry_t;

  // Load and store codes share their size encoding, so one helper serves both.
  function automatic logic [3:0] byte_mask(input logic [2:0] acc_type, input logic [1:0] lsb);
    logic [3:0] m;
    case (acc_type)
      3'b000, 3'b100: m = 4'b0001 << lsb;
      3'b001, 3'b101: m = 4'b0011 << lsb;
      3'b010:         m = 4'b1111;
      default:        m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_aligner.sv
// Combinational store alignment: byte-lane mask, lane-shifted data and misalignment detection.
module store_aligner
  import rv_mem_pkg::*;
(
  input  logic [2:0]  st_type,
  input  logic [1:0]  st_lsb,
  input  logic [31:0] st_data,
  output logic [3:0]  al_mask,
  output logic [31:0] al_data,
  output logic        al_misaligned,
  output logic        al_is_store
);

  always_comb begin
    al_is_store   = 1'b0;
    al_misaligned = 1'b0;
    case (st_type)
      ST_SB: al_is_store = 1'b1;
      ST_SH: begin
        al_is_store   = 1'b1;
        al_misaligned = st_lsb[0];
      end
      ST_SW: begin
        al_is_store   = 1'b1;
        al_misaligned = (st_lsb != 2'b00);
      end
      default: al_is_store = 1'b0;
    endcase
  end

  // Codes that only exist for loads (LBU/LHU) must not produce a store mask.
  assign al_mask = al_is_store ? byte_mask(st_type, st_lsb) : 4'b0000;
  assign al_data = st_data << {st_lsb, 3'b000};

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns MEM-stage stores, queues them and drains one per granted cycle to the cache.
// Define STORE_FWD_EN to forward from the youngest fully-covering entry instead of stalling the load.
module store_write_buffer
  import rv_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [2:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_ready,
  output logic              misalign,
  input  logic              ld_valid,
  input  logic [2:0]        ld_type,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              ld_fwd_valid,
  output logic [31:0]       ld_fwd_data,
  input  logic              cache_grant,
  output logic [3:0]        cache_write_en,
  output logic [ADDR_W-3:0] cache_addr,
  output logic [31:0]       cache_in_data,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               misalign_q, misalign_d;

  logic [3:0]         al_mask;
  logic [31:0]        al_data;
  logic               al_misaligned;
  logic               al_is_store;
  logic               full;
  logic               do_push;
  logic               do_pop;
  sb_entry_t          new_entry;
  sb_entry_t          head;

  logic [3:0]         ld_mask;
  logic [WADDR_W-1:0] ld_waddr;
  logic [PTR_W-1:0]   idx;
  logic               any_overlap;

  store_aligner u_aligner (
    .st_type       (st_type),
    .st_lsb        (st_addr[1:0]),
    .st_data       (st_data),
    .al_mask       (al_mask),
    .al_data       (al_data),
    .al_misaligned (al_misaligned),
    .al_is_store   (al_is_store)
  );

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign misalign = misalign_q;

  assign do_push = st_valid && st_ready && al_is_store && !al_misaligned;
  assign do_pop  = cache_grant && !empty;

  assign new_entry = '{waddr: WADDR_W'(st_addr[ADDR_W-1:2]), mask: al_mask, data: al_data};

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
    misalign_d = st_valid && al_is_store && al_misaligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (do_push) fifo_q[wr_ptr_q] <= new_entry;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign head           = fifo_q[rd_ptr_q];
  assign cache_write_en = empty ? 4'b0000 : head.mask;
  assign cache_addr     = head.waddr[ADDR_W-3:0];
  assign cache_in_data  = head.data;

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] young_idx;
  sb_entry_t        young;
  logic             covers;
`endif

  // Walk from oldest to youngest so the last hit is the youngest overlapping entry.
  always_comb begin
    ld_mask     = byte_mask(ld_type, ld_addr[1:0]);
    ld_waddr    = WADDR_W'(ld_addr[ADDR_W-1:2]);
    any_overlap = 1'b0;
    idx         = '0;
`ifdef STORE_FWD_EN
    young_idx   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (fifo_q[idx].waddr == ld_waddr) &&
          ((fifo_q[idx].mask & ld_mask) != 4'b0000)) begin
        any_overlap = 1'b1;
`ifdef STORE_FWD_EN
        young_idx   = idx;
`endif
      end
    end
  end

`ifdef STORE_FWD_EN
  assign young        = fifo_q[young_idx];
  assign covers       = ((young.mask & ld_mask) == ld_mask);
  assign ld_fwd_valid = ld_valid && any_overlap && covers;
  assign ld_hazard    = ld_valid && any_overlap && !covers;
  assign ld_fwd_data  = ld_fwd_valid ? young.data : 32'h0;
`else
  assign ld_hazard    = ld_valid && any_overlap;
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = 32'h0;
`endif

endmodule
